// File: rtl/sd_cmd_response_rx_if.sv
// Controller-facing bundle for the SD CMD-line response receiver.
// Signal prefixes are from the receiver's point of view: i_ flows into it, o_ flows out of it.
interface sd_cmd_response_rx_if;
   logic          i_cmd_in;
   logic          i_expect;
   logic [1:0]    i_resp_type;
   logic [5:0]    i_exp_index;
   logic          o_busy;
   logic          o_resp_valid;
   logic [5:0]    o_resp_index;
   logic [31:0]   o_resp_arg;
   logic [119:0]  o_resp_long;
   logic          o_crc_error;
   logic          o_frame_error;
   logic          o_timeout;
   logic          o_index_error;

   modport master (
      output i_cmd_in, i_expect, i_resp_type, i_exp_index,
      input  o_busy, o_resp_valid, o_resp_index, o_resp_arg, o_resp_long,
      input  o_crc_error, o_frame_error, o_timeout, o_index_error
   );

   modport slave (
      input  i_cmd_in, i_expect, i_resp_type, i_exp_index,
      output o_busy, o_resp_valid, o_resp_index, o_resp_arg, o_resp_long,
      output o_crc_error, o_frame_error, o_timeout, o_index_error
   );
endinterface

// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: waits for the start bit, deserialises 48/136-bit frames, checks CRC7/framing.
// Optional macro SD_RESP_INDEX_CHECK_EN compares the received index of CRC-carrying 48-bit frames to exp_index.
module sd_cmd_response_rx #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_WIDTH       = 7
) (
   input  logic              clk,
   input  logic              rst,
   sd_cmd_response_rx_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV, S_DONE} state_t;

   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_WIDTH-1:0] TO_ONE  = TO_WIDTH'(1);

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_type;
   logic [TO_WIDTH-1:0]  r_to_cnt;
   logic [7:0]           r_bit_cnt;
   logic [134:0]         r_shift;
   logic [6:0]           r_crc;
   logic [5:0]           r_index;
   logic [31:0]          r_arg;
   logic [119:0]         r_long;
   logic                 r_crc_err;
   logic                 r_frame_err;
   logic                 r_timeout;
   logic                 r_index_err;

   logic                 w_busy;
   logic                 w_valid;
   logic                 w_is_long;
   logic [7:0]           w_last_cnt;
   logic                 w_end;
   logic                 w_to_hit;
   logic                 w_crc_en;
   logic [6:0]           w_crc_next;
   logic [135:0]         w_frame;
   logic                 w_unused_bits;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // Bit counter holds the frame position (0 = start bit) of the bit sampled this cycle.
   assign w_is_long  = (r_type == 2'b10);
   assign w_last_cnt = w_is_long ? 8'd135 : 8'd47;
   assign w_end      = (r_state == S_RECV) && (r_bit_cnt == w_last_cnt);
   assign w_to_hit   = bus.i_cmd_in && (r_to_cnt == TO_LAST);
   assign w_crc_en   = w_is_long ? ((r_bit_cnt >= 8'd8) && (r_bit_cnt <= 8'd127))
                                 : (r_bit_cnt <= 8'd39);
   assign w_crc_next = crc7_step(r_crc, bus.i_cmd_in);
   assign w_frame    = {r_shift, bus.i_cmd_in};

   // Start bit and R2 reserved bits carry no information.
   assign w_unused_bits = ^{w_frame[135], w_frame[133:128]};

   always_comb begin
      w_next  = r_state;
      w_busy  = 1'b1;
      w_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.i_expect) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (!bus.i_cmd_in)  w_next = S_RECV;
            else if (w_to_hit)  w_next = S_DONE;
         end
         S_RECV: begin
            if (w_end) w_next = S_DONE;
         end
         S_DONE: begin
            w_valid = 1'b1;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

`ifdef SD_RESP_INDEX_CHECK_EN
   logic [5:0] r_exp_index;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp_index <= '0;
         r_index_err <= 1'b0;
      end else if (r_state == S_IDLE && bus.i_expect) begin
         r_exp_index <= bus.i_exp_index;
         r_index_err <= 1'b0;
      end else if (w_end && !w_is_long && r_type != 2'b01) begin
         r_index_err <= (w_frame[45:40] != r_exp_index);
      end
   end
`else
   logic w_unused_exp;
   assign w_unused_exp = ^bus.i_exp_index;
   assign r_index_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_type      <= 2'b00;
         r_to_cnt    <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_crc       <= '0;
         r_index     <= '0;
         r_arg       <= '0;
         r_long      <= '0;
         r_crc_err   <= 1'b0;
         r_frame_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (bus.i_expect) begin
                  r_type      <= bus.i_resp_type;
                  r_to_cnt    <= '0;
                  r_crc_err   <= 1'b0;
                  r_frame_err <= 1'b0;
                  r_timeout   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (!bus.i_cmd_in) begin
                  // The start bit is 0, so a cleared shifter already holds it.
                  r_bit_cnt <= 8'd1;
                  r_crc     <= '0;
                  r_shift   <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_ONE;
                  if (w_to_hit) r_timeout <= 1'b1;
               end
            end
            S_RECV: begin
               r_shift   <= w_frame[134:0];
               r_bit_cnt <= r_bit_cnt + 8'd1;
               if (w_crc_en) r_crc <= w_crc_next;
               if (w_end) begin
                  if (w_is_long) begin
                     r_long      <= w_frame[127:8];
                     r_index     <= 6'h3F;
                     r_crc_err   <= (w_frame[7:1] != r_crc);
                     r_frame_err <= w_frame[134] | ~w_frame[0];
                  end else begin
                     r_index     <= w_frame[45:40];
                     r_arg       <= w_frame[39:8];
                     r_crc_err   <= (r_type != 2'b01) && (w_frame[7:1] != r_crc);
                     r_frame_err <= w_frame[46] | ~w_frame[0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy        = w_busy;
   assign bus.o_resp_valid  = w_valid;
   assign bus.o_resp_index  = r_index;
   assign bus.o_resp_arg    = r_arg;
   assign bus.o_resp_long   = r_long;
   assign bus.o_crc_error   = r_crc_err;
   assign bus.o_frame_error = r_frame_err;
   assign bus.o_timeout     = r_timeout;
   assign bus.o_index_error = r_index_err;
endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Directed bench for sd_cmd_response_rx: R7/R3/R2 frames, CRC and framing faults, timeout, reset abort.
module tb_sd_cmd_response_rx;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   localparam logic [47:0]  R7_OK    = 48'h08_0000_01AA_13;
   localparam logic [47:0]  R7_BADC  = 48'h08_0000_01AB_13;
   localparam logic [47:0]  R7_BADE  = 48'h08_0000_01AA_12;
   localparam logic [47:0]  R7_BADT  = 48'h48_0000_01AA_13;
   localparam logic [47:0]  R3_OK    = 48'h3F_80FF_8000_FF;
   localparam logic [119:0] CID      = 120'h1D4144534420202010A0B3C4D5E6F7;

   sd_cmd_response_rx_if bus();

   sd_cmd_response_rx #(.TIMEOUT_CYCLES(64), .TO_WIDTH(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=stuck expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CRC7 by long division of d*x^7 by x^7+x^3+1.
   function automatic logic [6:0] crc7_div(input logic [119:0] d);
      logic [126:0] m;
      m = {d, 7'b0};
      for (int i = 126; i >= 7; i--)
         if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
      return m[6:0];
   endfunction

   task automatic run_frame(input string tag, input logic [135:0] frame, input int nbits,
                            input logic [1:0] rtype, input logic [5:0] eidx,
                            input int gap, input int mid);
      int early;
      early = 0;
      @(negedge clk);
      bus.i_resp_type = rtype;
      bus.i_exp_index = eidx;
      bus.i_expect    = 1'b1;
      @(negedge clk);
      bus.i_expect = 1'b0;
      chk({tag, ".busy_wait"}, bus.o_busy, 1);
      chk({tag, ".flags_clr"}, {bus.o_crc_error, bus.o_frame_error, bus.o_timeout, bus.o_index_error}, 0);
      repeat (gap - 1) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.i_cmd_in = frame[i];
         if (i == mid) begin
            bus.i_expect    = 1'b1;
            bus.i_resp_type = 2'b01;
         end else begin
            bus.i_expect    = 1'b0;
            bus.i_resp_type = rtype;
         end
         @(negedge clk);
         if (i != 0 && bus.o_resp_valid) early++;
      end
      bus.i_expect    = 1'b0;
      bus.i_resp_type = rtype;
      bus.i_cmd_in    = 1'b1;
      chk({tag, ".no_early"}, early, 0);
      chk({tag, ".valid"}, bus.o_resp_valid, 1);
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      chk({tag, ".valid_off"}, bus.o_resp_valid, 0);
      chk({tag, ".busy_off"}, bus.o_busy, 0);
   endtask

   initial begin
      logic [135:0] f;
      logic         exp_ierr;
      int           lat;
      int           vcount;

      rst             = 1'b1;
      bus.i_cmd_in    = 1'b1;
      bus.i_expect    = 1'b0;
      bus.i_resp_type = 2'b00;
      bus.i_exp_index = 6'd0;
      repeat (3) @(negedge clk);
      chk("rst.busy", bus.o_busy, 0);
      chk("rst.valid", bus.o_resp_valid, 0);
      chk("rst.fields", {bus.o_resp_index, bus.o_resp_arg}, 0);
      chk("rst.long", bus.o_resp_long, 0);
      chk("rst.flags", {bus.o_crc_error, bus.o_frame_error, bus.o_timeout, bus.o_index_error}, 0);
      rst = 1'b0;

      // Low CMD in IDLE must not start anything.
      bus.i_cmd_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_low.busy", bus.o_busy, 0);
      bus.i_cmd_in = 1'b1;
      @(negedge clk);

      f = 136'(R7_OK);
      run_frame("r7", f, 48, 2'b00, 6'd8, 5, -1);
      chk("r7.index", bus.o_resp_index, 6'd8);
      chk("r7.arg", bus.o_resp_arg, 32'h0000_01AA);
      chk("r7.flags", {bus.o_crc_error, bus.o_frame_error, bus.o_timeout, bus.o_index_error}, 0);
      after_done("r7");

      f = 136'(R3_OK);
      run_frame("r3", f, 48, 2'b01, 6'd0, 2, -1);
      chk("r3.index", bus.o_resp_index, 6'h3F);
      chk("r3.arg", bus.o_resp_arg, 32'h80FF_8000);
      chk("r3.crc", bus.o_crc_error, 0);
      chk("r3.frame", bus.o_frame_error, 0);
      chk("r3.ierr", bus.o_index_error, 0);
      after_done("r3");

      f = 136'(R7_BADC);
      run_frame("badcrc", f, 48, 2'b00, 6'd8, 3, -1);
      chk("badcrc.crc", bus.o_crc_error, 1);
      chk("badcrc.frame", bus.o_frame_error, 0);
      after_done("badcrc");

      f = 136'(R7_BADE);
      run_frame("badend", f, 48, 2'b00, 6'd8, 1, -1);
      chk("badend.frame", bus.o_frame_error, 1);
      chk("badend.crc", bus.o_crc_error, 0);
      after_done("badend");

      f = 136'(R7_BADT);
      run_frame("badtx", f, 48, 2'b00, 6'd8, 4, -1);
      chk("badtx.frame", bus.o_frame_error, 1);
      after_done("badtx");

      f = 136'(R7_OK);
      run_frame("type11", f, 48, 2'b11, 6'd8, 2, -1);
      chk("type11.index", bus.o_resp_index, 6'd8);
      chk("type11.arg", bus.o_resp_arg, 32'h0000_01AA);
      chk("type11.flags", {bus.o_crc_error, bus.o_frame_error, bus.o_timeout, bus.o_index_error}, 0);
      after_done("type11");

      // No start bit: timeout pulse 65 cycles after expect, expect during DONE ignored.
      @(negedge clk);
      bus.i_resp_type = 2'b00;
      bus.i_expect    = 1'b1;
      lat = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) bus.i_expect = 1'b0;
         if (bus.o_resp_valid) begin
            lat = k;
            break;
         end
      end
      chk("to.latency", lat, 65);
      chk("to.flag", bus.o_timeout, 1);
      chk("to.crc", bus.o_crc_error, 0);
      bus.i_expect = 1'b1;
      @(negedge clk);
      bus.i_expect = 1'b0;
      chk("to.busy_after", bus.o_busy, 0);
      @(negedge clk);
      chk("to.done_expect_ignored", bus.o_busy, 0);

      f = {2'b00, 6'h3F, CID, crc7_div(CID), 1'b1};
      run_frame("r2", f, 136, 2'b10, 6'd0, 3, 70);
      chk("r2.long", bus.o_resp_long, CID);
      chk("r2.index", bus.o_resp_index, 6'h3F);
      chk("r2.arg_hold", bus.o_resp_arg, 32'h0000_01AA);
      chk("r2.flags", {bus.o_crc_error, bus.o_frame_error, bus.o_timeout, bus.o_index_error}, 0);
      after_done("r2");

      // Reset in the middle of a frame aborts it silently.
      f = 136'(R7_OK);
      @(negedge clk);
      bus.i_resp_type = 2'b00;
      bus.i_expect    = 1'b1;
      @(negedge clk);
      bus.i_expect = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 47; i >= 28; i--) begin
         bus.i_cmd_in = f[i];
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.busy", bus.o_busy, 0);
      chk("abort.long", bus.o_resp_long, 0);
      chk("abort.fields", {bus.o_resp_index, bus.o_resp_arg}, 0);
      vcount = 0;
      for (int i = 27; i >= 0; i--) begin
         bus.i_cmd_in = f[i];
         @(negedge clk);
         if (bus.o_resp_valid) vcount++;
      end
      bus.i_cmd_in = 1'b1;
      chk("abort.no_valid", vcount, 0);

`ifdef SD_RESP_INDEX_CHECK_EN
      exp_ierr = 1'b1;
`else
      exp_ierr = 1'b0;
`endif
      run_frame("fresh", f, 48, 2'b00, 6'd7, 5, -1);
      chk("fresh.index", bus.o_resp_index, 6'd8);
      chk("fresh.arg", bus.o_resp_arg, 32'h0000_01AA);
      chk("fresh.crc", bus.o_crc_error, 0);
      chk("fresh.ierr", bus.o_index_error, exp_ierr);
      after_done("fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sd_cmd_response_rx.md
Name: sd_cmd_response_rx

Overview:
- Host-side receiver for SD card responses on the CMD line. It is the return path for the command shifter.
- After a command is sent, it waits for the card's start bit and deserialises a 48-bit response (R1/R1b/R3/R6/R7) or a 136-bit response (R2).
- It checks CRC7, the transmission bit and the end bit, and flags a no-response timeout.
- It presents the decoded fields to the SD controller FSM with a one-cycle valid pulse.

Parameters:
- TIMEOUT_CYCLES, 64: maximum clk cycles to wait for a start bit (NCR) before flagging timeout.
- TO_WIDTH, 7: width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; CMD line sampled on rising edge
- rst  input  1  synchronous reset, active-high
- cmd_in  input  1  CMD line value (tri-state input side, host not driving)
- expect  input  1  one-cycle pulse: response expected; accepted only when busy=0
- resp_type  input  2  sampled with expect: 00 = 48-bit with CRC, 01 = 48-bit without CRC (R3), 10 = 136-bit (R2), 11 = treated as 00
- exp_index  input  6  expected response index (optional feature only)
- busy  output  1  high from accepted expect until resp_valid/timeout cycle ends
- resp_valid  output  1  one-cycle pulse: frame complete or timed out
- resp_index  output  6  bits [45:40] of 48-bit frame; 6'h3F for R2
- resp_arg  output  32  bits [39:8] of 48-bit frame
- resp_long  output  120  R2 bits [127:8] (CID/CSD without CRC/end bit)
- crc_error  output  1  received CRC7 ≠ computed
- frame_error  output  1  transmission bit ≠ 0 or end bit ≠ 1
- timeout  output  1  no start bit within TIMEOUT_CYCLES
- index_error  output  1  see Optional Feature

Behaviour:
- Reset: state IDLE; all outputs 0; shift register, CRC register and counters cleared. Reset mid-frame aborts; no resp_valid is produced.
- States: IDLE, WAIT, RECV, DONE.
- IDLE: when expect=1, latch resp_type, clear all error flags and the timeout counter, then go to WAIT.
- WAIT: each cycle with cmd_in=1, increment the timeout counter. If cmd_in=0, this cycle is the start bit: go to RECV with bit count = 1 and CRC register = 0. If the counter reaches TIMEOUT_CYCLES while cmd_in=1, set timeout=1 and go to DONE.
- RECV: shift cmd_in in MSB-first each cycle and increment the bit count. Frame length is 48 for types 00/01/11 and 136 for type 10. The edge that samples bit N-1 (end bit) moves the FSM to DONE.
- CRC7: polynomial x^7+x^3+1, initial value 0.
  - 48-bit frames: computed over the first 40 bits including start and transmission bits; compared to bits [7:1].
  - 136-bit frames: computed over bits [127:8]; start, transmission and reserved bits are excluded.
  - Type 01: the CRC is not checked and crc_error stays 0.
- frame_error is set if the transmission bit (second bit) is 1 or the end bit is 0.
- DONE: lasts exactly one cycle. resp_valid=1, busy=1; fields and flags are already registered. Next state is IDLE.
- Latency: resp_valid is high on the cycle following the edge that samples the end bit. Timeout is reported TIMEOUT_CYCLES+1 cycles after expect.
- resp_index, resp_arg, resp_long and the error flags hold their values after DONE until the next accepted expect. resp_long is left unchanged for 48-bit frames; resp_arg and resp_index are unchanged for 136-bit frames, except resp_index is forced to 6'h3F.
- expect while busy=1, including the DONE cycle, is ignored.
- cmd_in=0 in IDLE is ignored; a start bit is recognised only in WAIT.

Optional Feature:
- Macro SD_RESP_INDEX_CHECK_EN.
- Defined: on 48-bit frames of type 00/11, index_error=1 if the received index ≠ exp_index, where exp_index is latched with expect. Types 01/10 and timeouts never set it.
- Undefined: exp_index is ignored and index_error is constant 0.

Test Plan:
- R7 frame 0x08_0000_01AA_13 driven MSB-first 5 cycles after expect (type 00) -> resp_valid 1 cycle after end bit; resp_index=8, resp_arg=0x000001AA, all error flags 0.
- R3 frame 0x3F_80FF_8000_FF (type 01) -> resp_index=6'h3F, resp_arg=0x80FF8000, crc_error=0.
- The same R7 frame with arg bit 0 flipped -> crc_error=1, frame_error=0; with end bit forced to 0 -> frame_error=1.
- expect (type 00) with cmd_in held 1 -> timeout=1 and resp_valid exactly 65 cycles after expect; busy low the cycle after.
- R2 frame with bench-computed CRC over CID 0x1D4144534420202010A0B3C4D5E6F7 -> resp_long equals the CID, crc_error=0. A second expect pulsed mid-frame is ignored.
- rst asserted mid-RECV, then a fresh expect plus R7 frame -> no resp_valid from the aborted frame; second frame decodes correctly. With SD_RESP_INDEX_CHECK_EN and exp_index=7 -> index_error=1.
